// File: rtl/prime_pkg.sv
// Shared types and constants for the trial-division primality controller.
// Pure declarations: no logic, no latency, no flow control.
// Imported by prime_ctrl and by anything that wraps it with the register bank.
package prime_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] FIRST_DIV = 16'd2;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        CHECK = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/prime_ctrl.sv
// Trial-division primality controller driving an external rem/div/res register bank.
// Latency: data-dependent; one bank update per clock, outputs combinational from state.
// No backpressure: strobes are single-cycle and the bank always captures them.
module prime_ctrl
    import prime_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] div,
    input  logic             res,
    output logic             remld,
    output logic [WIDTH-1:0] remi,
    output logic             divld,
    output logic [WIDTH-1:0] divi,
    output logic             resld,
    output logic             resi,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_nxt;

    // The result bit is owned by the bank; the controller only ever clears it.
    logic unused_res;
    assign unused_res = res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        remld     = 1'b0;
        remi      = '0;
        divld     = 1'b0;
        divi      = '0;
        resld     = 1'b0;
        resi      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state)
            SETUP: begin
                remld = 1'b1;
                remi  = n;
                divld = 1'b1;
                divi  = FIRST_DIV;
                if (n < FIRST_DIV) begin
                    resld     = 1'b1;
                    resi      = 1'b0;
                    state_nxt = DONE;
                end else begin
                    state_nxt = CHECK;
                end
            end

            CHECK: begin
                // Every divisor below n has been tried: res keeps its reset value of 1.
                if (div >= n) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SUB;
                end
            end

            SUB: begin
                if (rem >= div) begin
                    remld = 1'b1;
                    remi  = rem - div;
                end else if (rem == '0) begin
                    resld     = 1'b1;
                    resi      = 1'b0;
                    state_nxt = DONE;
                end else begin
                    // div < n here, so the increment cannot wrap.
                    divld     = 1'b1;
                    divi      = div + 1'b1;
                    remld     = 1'b1;
                    remi      = n;
                    state_nxt = CHECK;
                end
            end

            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end

            default: begin
                state_nxt = SETUP;
            end
        endcase

        // The bank is also in reset, so nothing may be loaded on that edge.
        if (rst) begin
            remld = 1'b0;
            divld = 1'b0;
            resld = 1'b0;
        end
    end

endmodule

// File: tb/tb_prime_ctrl.sv
// Bench for prime_ctrl: local register bank, expected-result scoreboard,
// and a negedge monitor logging strobes and checking reset/status invariants.
module tb_prime_ctrl;
    import prime_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] n   = 16'd0;
    logic [15:0] rem;
    logic [15:0] div;
    logic        res;
    logic        remld;
    logic [15:0] remi;
    logic        divld;
    logic [15:0] divi;
    logic        resld;
    logic        resi;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    prime_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .n     (n),
        .rem   (rem),
        .div   (div),
        .res   (res),
        .remld (remld),
        .remi  (remi),
        .divld (divld),
        .divi  (divi),
        .resld (resld),
        .resi  (resi),
        .busy  (busy),
        .done  (done)
    );

    // Register bank that the controller drives.
    always @(posedge clk) begin
        if (rst) begin
            rem <= n;
            div <= 16'd2;
            res <= 1'b1;
        end else begin
            if (remld) rem <= remi;
            if (divld) div <= divi;
            if (resld) res <= resi;
        end
    end

    int checks = 0;
    int errors = 0;

    int          edge_cnt;
    int          resld_cnt;
    int          resld_edge;
    int          strobe_cnt;
    logic [15:0] div_at_resld;
    logic        resi_at_resld;
    logic [15:0] rem_log[$];
    logic [15:0] div_log[$];

    typedef struct {
        logic [15:0] n;
        logic        exp_res;
        int          exp_edges;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        checks++;
        if (done && busy) begin
            errors++;
            $display("FAIL done_busy_exclusive: done=%b busy=%b, required not both high", done, busy);
        end
        if (rst) begin
            checks++;
            if ({remld, divld, resld} !== 3'b000) begin
                errors++;
                $display("FAIL strobe_in_reset: remld/divld/resld=%b, required 000", {remld, divld, resld});
            end
        end else begin
            if (remld) rem_log.push_back(remi);
            if (divld) div_log.push_back(divi);
            if (remld || divld || resld) strobe_cnt++;
            if (resld) begin
                resld_cnt++;
                resld_edge    = edge_cnt + 1;
                div_at_resld  = div;
                resi_at_resld = resi;
            end
        end
    end

    function automatic logic is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_logs();
        rem_log.delete();
        div_log.delete();
        resld_cnt  = 0;
        resld_edge = -1;
        strobe_cnt = 0;
    endtask

    // One reset edge with the new operand, then release; the test starts at the next edge.
    task automatic start(input logic [15:0] nv, input int exp_edges);
        exp_t e;
        e.n         = nv;
        e.exp_res   = is_prime(int'(nv));
        e.exp_edges = exp_edges;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n   = nv;
        rst = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Returns the number of rising edges after reset release at which done was first seen.
    task automatic wait_done(input int budget, output int edges, output bit ok);
        ok    = 1'b0;
        edges = -1;
        for (int i = 0; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                edges = i;
                ok    = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        n   = 16'd13;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        checks++;
        if (res !== 1'b1 || rem !== 16'd13) begin
            errors++;
            $display("FAIL reset_bank: res=%b rem=%0d, required res=1 rem=13", res, rem);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (remld !== 1'b1 || remi !== 16'd13 || divld !== 1'b1 || divi !== 16'd2 || resld !== 1'b0) begin
            errors++;
            $display("FAIL setup_strobes: remld=%b remi=%0d divld=%b divi=%0d resld=%b, required 1 13 1 2 0",
                     remld, remi, divld, divi, resld);
        end
    endtask

    task automatic test_edge_cases();
        logic [15:0] nv [4] = '{16'd0, 16'd1, 16'd2, 16'd4};
        int          ee [4] = '{1, 1, 2, 5};
        int          er [4] = '{1, 1, 0, 1};
        int          edges;
        bit          ok;
        exp_t        e;
        for (int k = 0; k < 4; k++) begin
            start(nv[k], ee[k]);
            wait_done(200, edges, ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL edge_timeout n=%0d: done never seen within 200 cycles", e.n);
            end
            checks++;
            if (edges != e.exp_edges || res !== e.exp_res) begin
                errors++;
                $display("FAIL edge_result n=%0d: edges=%0d res=%b, required edges=%0d res=%b",
                         e.n, edges, res, e.exp_edges, e.exp_res);
            end
            checks++;
            if (resld_cnt != er[k]) begin
                errors++;
                $display("FAIL edge_resld_count n=%0d: pulses=%0d, required %0d", e.n, resld_cnt, er[k]);
            end
        end
        // The last run above was n=4.
        checks++;
        if (rem_log.size() != 3 || rem_log[0] !== 16'd4 || rem_log[1] !== 16'd2 || rem_log[2] !== 16'd0) begin
            errors++;
            $display("FAIL n4_rem_sequence: got %p, required 4,2,0", rem_log);
        end
        checks++;
        if (resld_edge != 5 || resi_at_resld !== 1'b0) begin
            errors++;
            $display("FAIL n4_resld: edge=%0d resi=%b, required edge=5 resi=0", resld_edge, resi_at_resld);
        end
    endtask

    task automatic test_known_values();
        int   edges;
        bit   ok;
        int   held;
        exp_t e;

        start(16'd7, -1);
        wait_done(500, edges, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || res !== e.exp_res) begin
            errors++;
            $display("FAIL n7_result: done_seen=%b res=%b, required done_seen=1 res=%b", ok, res, e.exp_res);
        end
        checks++;
        if (div_log.size() != 6 || div_log[0] !== 16'd2 || div_log[5] !== 16'd7) begin
            errors++;
            $display("FAIL n7_div_steps: got %p, required 2..7", div_log);
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (div_log[i] !== div_log[i-1] + 16'd1) begin
                    errors++;
                    $display("FAIL n7_div_step%0d: got %0d, required %0d", i, div_log[i], div_log[i-1] + 16'd1);
                end
            end
        end

        start(16'd9, -1);
        wait_done(500, edges, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || res !== e.exp_res || div_at_resld !== 16'd3) begin
            errors++;
            $display("FAIL n9_result: done_seen=%b res=%b div_at_resld=%0d, required 1 0 3",
                     ok, res, div_at_resld);
        end

        // done holds with no further bank activity until reset.
        held = strobe_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || strobe_cnt != held || res !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b strobes=%0d res=%b, required 1 0 %0d 0",
                     done, busy, strobe_cnt, res, held);
        end
    endtask

    task automatic test_mid_reset();
        int   edges;
        bit   ok;
        exp_t e;

        start(16'd65521, -1);
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_before_reset: busy=%b done=%b, required 1 0", busy, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (remld !== 1'b1 || remi !== 16'd65521 || divld !== 1'b1 || divi !== 16'd2 ||
            rem !== 16'd65521 || res !== 1'b1) begin
            errors++;
            $display("FAIL mid_back_to_setup: remld=%b remi=%0d divld=%b divi=%0d rem=%0d res=%b, required 1 65521 1 2 65521 1",
                     remld, remi, divld, divi, rem, res);
        end
        repeat (3000) @(negedge clk);
        checks++;
        if (done !== 1'b0 || resld_cnt != 0 || res !== 1'b1) begin
            errors++;
            $display("FAIL mid_rerun_progress: done=%b resld_pulses=%0d res=%b, required 0 0 1",
                     done, resld_cnt, res);
        end
        e = sb.pop_front();

        // Same interrupted-then-rerun flow on a prime small enough to finish.
        start(16'd251, -1);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done(20000, edges, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || res !== e.exp_res || resld_cnt != 0) begin
            errors++;
            $display("FAIL mid_rerun_complete n=%0d: done_seen=%b res=%b resld_pulses=%0d, required 1 %b 0",
                     e.n, ok, res, resld_cnt, e.exp_res);
        end
    endtask

    task automatic test_back_to_back();
        int   edges;
        bit   ok;
        exp_t e;
        logic [15:0] v;
        for (int k = 0; k < 12; k++) begin
            v = 16'($urandom_range(0, 400));
            start(v, -1);
            wait_done(30000, edges, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || res !== e.exp_res || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b n=%0d: done_seen=%b res=%b busy=%b, required 1 %b 0",
                         e.n, ok, res, busy, e.exp_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_cases();
        test_known_values();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_ctrl.md
PRIME_CTRL -- requirements
Module: prime_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset, shared with the data register bank.
REQ-002 n  input  16  operand under test, held in the register bank.
REQ-003 rem  input  16  current remainder from the register bank.
REQ-004 div  input  16  current trial divisor from the register bank.
REQ-005 res  input  1  current result bit (1 = prime) from the register bank.
REQ-006 remld / remi  output  1 / 16  remainder load strobe and load value.
REQ-007 divld / divi  output  1 / 16  divisor load strobe and load value.
REQ-008 resld / resi  output  1 / 1  result load strobe and load value.
REQ-009 busy  output  1  high while a test is in progress.
REQ-010 done  output  1  high once res is final; holds until rst.

Function
REQ-011 SHALL implement a registered FSM with states SETUP, CHECK, SUB and DONE; all outputs are combinational from state and inputs.
REQ-012 Load strobes are one-cycle pulses; the bank captures on the same edge; when a strobe is low, its data value is don't-care.
REQ-013 SETUP: remld=1, remi=n; divld=1, divi=2.
REQ-014 SETUP, n<2: also resld=1, resi=0; next state is DONE.
REQ-015 SETUP, n>=2: next state is CHECK.
REQ-016 CHECK: div>=n -> DONE with res untouched (stays 1); else -> SUB; no strobes.
REQ-017 SUB, rem>=div: remld=1, remi=rem-div; stay in SUB.
REQ-018 SUB, rem<div and rem==0: resld=1, resi=0; next state is DONE.
REQ-019 SUB, rem<div and rem!=0: divld=1, divi=div+1, remld=1, remi=n; next state is CHECK.
REQ-020 All arithmetic is unsigned 16-bit; rem-div only in the rem>=div case, so no underflow; div+1 only when div<n, so no wrap.
REQ-021 DONE: no strobes; done=1, busy=0; hold until rst.
REQ-022 busy=1 in SETUP, CHECK and SUB.
REQ-023 Edge-count examples, E1 = first edge with rst low: n=2 -> done after E2, res=1; n=0 -> done after E1, res=0.

Reset
REQ-024 rst=1 at a clock edge -> state=SETUP regardless of current state (mid-test included); the bank reloads n and sets res=1 on the same edge.
REQ-025 While rst=1, all strobes SHALL be 0.
REQ-026 The test starts automatically on the first edge with rst=0; there is no separate start input.

Structure
REQ-027 Package prime_pkg holds the state encoding typedef, WIDTH=16 and FIRST_DIV=2.
REQ-028 No sub-module; the controller is one flat FSM.
REQ-029 prime_ctrl and the register bank are connected by a separate top-level wrapper, which is outside this block.

Verification
REQ-030 n=0 and n=1 -> done after E1, res=0, exactly one resld pulse.
REQ-031 n=2 -> done after E2, res=1, resld never pulsed.
REQ-032 n=4 -> rem sequence 4,2,0; resld pulse with resi=0 at E5; done after E5.
REQ-033 n=7 -> res=1; div steps 2..7; done asserted.
REQ-034 n=9 -> res=0 with div=3 at resld; done asserted.
REQ-035 Reset mid-test: n=65521, rst pulsed after 100 cycles -> state returns to SETUP; the test re-runs to res=1.
REQ-036 Bench checks throughout: no strobe while rst=1; done and busy never both high.
